// File: rtl/open_list_arbiter_if.sv
// open_list_arbiter_if: requester-side bundle of the open-list arbiter.
//   i_req_valid : per-requester request pending
//   i_req_op    : 2 bits per requester (00 enq, 01 deq, 10 replace, 11 reserved)
//   i_req_data  : DATA_WIDTH bits per requester (node f-value)
//   o_req_ready : one-hot acceptance pulse
//   o_rsp_valid : one-hot completion pulse
//   o_rsp_err   : completion carries an error
//   o_rsp_data  : popped minimum for dequeue/replace, 0 otherwise
// Modports: master = requester side, slave = arbiter side.
interface open_list_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [2*NUM_REQ-1:0]          i_req_op;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic [NUM_REQ-1:0]            o_rsp_valid;
    logic                          o_rsp_err;
    logic [DATA_WIDTH-1:0]         o_rsp_data;

    modport master (
        output i_req_valid, i_req_op, i_req_data,
        input  o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data
    );

    modport slave (
        input  i_req_valid, i_req_op, i_req_data,
        output o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data
    );
endinterface

// File: rtl/open_list_arbiter.sv
// open_list_arbiter: round-robin scheduler sharing one min-first open-list
// queue among NUM_REQ requesters. One queue operation at a time, followed by
// a SETTLE_CYCLES window so the systolic queue can re-sort.
// Ports:
//   CLK, RSTn              : clock, async active-low reset
//   bus (slave)            : requester request/response bundle
//   o_busy                 : FSM not idle
//   o_q_wrt, o_q_read      : queue strobes (single-cycle)
//   o_q_node_f             : queue data input
//   i_q_full, i_q_empty    : queue status
//   i_q_node_f             : queue current minimum
// Build option: OPEN_LIST_ARB_COALESCE_EN merges a dequeue winner with the
// next pending enqueue requester into a single replace.
module open_list_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    open_list_arbiter_if.slave    bus,
    output logic                  o_busy,
    output logic                  o_q_wrt,
    output logic                  o_q_read,
    output logic [DATA_WIDTH-1:0] o_q_node_f,
    input  logic                  i_q_full,
    input  logic                  i_q_empty,
    input  logic [DATA_WIDTH-1:0] i_q_node_f
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0] OP_ENQ = 2'b00;
    localparam logic [1:0] OP_DEQ = 2'b01;
    localparam logic [1:0] OP_REP = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESPOND} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic [1:0]             op_q, op_d;
    logic                   err_q, err_d;
    logic [DATA_WIDTH-1:0]  min_q, min_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   busy_q, busy_d;
    logic                   wrt_q, wrt_d;
    logic                   read_q, read_d;
    logic [DATA_WIDTH-1:0]  node_f_q, node_f_d;

    logic [1:0]             req_op_c   [NUM_REQ];
    logic [DATA_WIDTH-1:0]  req_data_c [NUM_REQ];
    logic                   win_vld_c;
    logic [IDX_W-1:0]       win_c;
    logic                   legal_c;
    logic [IDX_W-1:0]       last_gnt_c;
    logic [NUM_REQ-1:0]     rsp_mask_c;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        return IDX_W'((int'(base) + off) % int'(NUM_REQ));
    endfunction

    // Unpack per-requester op/data fields
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_op_c[i]   = bus.i_req_op[2*i +: 2];
            req_data_c[i] = bus.i_req_data[i*int'(DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    // Winner: first valid requester at or after the pointer, wrapping
    always_comb begin
        win_vld_c = 1'b0;
        win_c     = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (bus.i_req_valid[rr_idx(ptr_q, i)]) begin
                win_vld_c = 1'b1;
                win_c     = rr_idx(ptr_q, i);
            end
        end
    end

    // Replace needs only a non-empty queue: it pops before it pushes
    always_comb begin
        case (req_op_c[win_c])
            OP_ENQ:         legal_c = !i_q_full;
            OP_DEQ, OP_REP: legal_c = !i_q_empty;
            default:        legal_c = 1'b0;
        endcase
    end

`ifdef OPEN_LIST_ARB_COALESCE_EN
    logic             merged_q, merged_d;
    logic [IDX_W-1:0] gnt2_q, gnt2_d;
    logic             nxt_vld_c;
    logic [IDX_W-1:0] nxt_c;
    logic             merge_c;

    // Next valid requester after the winner in round-robin order
    always_comb begin
        nxt_vld_c = 1'b0;
        nxt_c     = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 1; i--) begin
            if (bus.i_req_valid[rr_idx(win_c, i)]) begin
                nxt_vld_c = 1'b1;
                nxt_c     = rr_idx(win_c, i);
            end
        end
    end

    assign merge_c    = win_vld_c && nxt_vld_c && (req_op_c[win_c] == OP_DEQ) &&
                        (req_op_c[nxt_c] == OP_ENQ) && !i_q_empty;
    assign last_gnt_c = merged_q ? gnt2_q : gnt_q;
    assign rsp_mask_c = (NUM_REQ'(1) << gnt_q) | (merged_q ? (NUM_REQ'(1) << gnt2_q) : '0);
`else
    assign last_gnt_c = gnt_q;
    assign rsp_mask_c = NUM_REQ'(1) << gnt_q;
`endif

    // Next-state and registered-output logic; outputs are computed one cycle
    // ahead so they line up with the state they belong to
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        op_d        = op_q;
        err_d       = err_q;
        min_d       = min_q;
        cnt_d       = cnt_q;
        ready_d     = '0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        wrt_d       = 1'b0;
        read_d      = 1'b0;
        node_f_d    = '0;
`ifdef OPEN_LIST_ARB_COALESCE_EN
        merged_d    = merged_q;
        gnt2_d      = gnt2_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_vld_c) begin
                    state_d = S_ISSUE;
                    gnt_d   = win_c;
                    op_d    = req_op_c[win_c];
                    err_d   = !legal_c;
                    ready_d = NUM_REQ'(1) << win_c;
                    if (legal_c) begin
                        wrt_d    = (req_op_c[win_c] == OP_ENQ) || (req_op_c[win_c] == OP_REP);
                        read_d   = (req_op_c[win_c] == OP_DEQ) || (req_op_c[win_c] == OP_REP);
                        node_f_d = req_data_c[win_c];
                    end
`ifdef OPEN_LIST_ARB_COALESCE_EN
                    merged_d = merge_c;
                    if (merge_c) begin
                        gnt2_d   = nxt_c;
                        ready_d  = (NUM_REQ'(1) << win_c) | (NUM_REQ'(1) << nxt_c);
                        wrt_d    = 1'b1;
                        read_d   = 1'b1;
                        node_f_d = req_data_c[nxt_c];
                    end
`endif
                end
            end
            S_ISSUE: begin
                // Minimum before the strobe lands is the value being popped
                min_d = i_q_node_f;
                cnt_d = '0;
                if (err_q) begin
                    state_d     = S_RESPOND;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d     = S_RESPOND;
                    rsp_valid_d = rsp_mask_c;
                    rsp_data_d  = ((op_q == OP_DEQ) || (op_q == OP_REP)) ? min_q : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
                ptr_d   = (last_gnt_c == IDX_W'(NUM_REQ - 1)) ? '0 : last_gnt_c + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            op_q        <= '0;
            err_q       <= 1'b0;
            min_q       <= '0;
            cnt_q       <= '0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            wrt_q       <= 1'b0;
            read_q      <= 1'b0;
            node_f_q    <= '0;
`ifdef OPEN_LIST_ARB_COALESCE_EN
            merged_q    <= 1'b0;
            gnt2_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            op_q        <= op_d;
            err_q       <= err_d;
            min_q       <= min_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            wrt_q       <= wrt_d;
            read_q      <= read_d;
            node_f_q    <= node_f_d;
`ifdef OPEN_LIST_ARB_COALESCE_EN
            merged_q    <= merged_d;
            gnt2_q      <= gnt2_d;
`endif
        end
    end

    assign bus.o_req_ready = ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign o_busy          = busy_q;
    assign o_q_wrt         = wrt_q;
    assign o_q_read        = read_q;
    assign o_q_node_f      = node_f_q;
endmodule
